// File: rtl/rp_reset_pkg.sv
// rp_reset_pkg: shared definitions for the fault shutdown sequencer.
//   - seq_state_t : sequencer FSM states (encoding is visible on seq_state)
//   - RAMP_*      : channel ramp-state encodings; OFF means settled
//   - CAUSE_*     : bit positions inside fault_cause
//   - sat_inc()   : 32-bit saturating increment used by both counters
package rp_reset_pkg;

    typedef enum logic [1:0] {
        ST_MONITOR   = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_HALT      = 2'd2
    } seq_state_t;

    localparam logic [1:0] RAMP_OFF  = 2'b00;
    localparam logic [1:0] RAMP_UP   = 2'b01;
    localparam logic [1:0] RAMP_ON   = 2'b10;
    localparam logic [1:0] RAMP_DOWN = 2'b11;

    localparam int CAUSE_WDG  = 0;
    localparam int CAUSE_INST = 1;

    localparam int NUM_CH = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for one asynchronous pin plus a
// rising-edge pulse on the synchronized level.
//   clk, aresetn : clock, asynchronous active-low reset
//   async_in     : raw asynchronous pin
//   level        : synchronized level (SYNC_STAGES cycles after the pin)
//   rise         : one-cycle pulse while level is high for its first cycle
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse is decoded from flops only, so it is glitch-free; the consumer
    // acts on it at the next edge, giving SYNC_STAGES+1 cycles pin-to-action.
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;

endmodule

// File: rtl/fault_shutdown_sequencer.sv
// fault_shutdown_sequencer: watchdog / instant-reset supervisor that ramps
// enabled channels down and then holds the DAC path in reset until software
// clears the fault.
//   clk, aresetn                  : clock, asynchronous active-low reset
//   wdg_en, inst_en               : enable watchdog / instant-reset input
//   watchdog_in, instant_reset_in : asynchronous pins (heartbeat edge, level)
//   clear_fault                   : software clear, rising-edge sensitive
//   wdg_timeout, ramp_timeout     : cycle limits, 0 disables
//   ramping_enable, ramp_state_0/1: per-channel ramp control and status
//   start_ramp_down, dac_aresetn, reset_ack, seq_state, fault_cause,
//   ramp_timed_out                : registered status / control outputs
// Build option: FAULT_SEQ_RAMP_EN enables the RAMP_DOWN phase; without it
// every fault goes straight to HALT and the ramp outputs are tied low.
module fault_shutdown_sequencer
    import rp_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        wdg_en,
    input  logic        inst_en,
    input  logic        watchdog_in,
    input  logic        instant_reset_in,
    input  logic        clear_fault,
    input  logic [31:0] wdg_timeout,
    input  logic [31:0] ramp_timeout,
    input  logic [1:0]  ramping_enable,
    input  logic [1:0]  ramp_state_0,
    input  logic [1:0]  ramp_state_1,
    output logic [1:0]  start_ramp_down,
    output logic        dac_aresetn,
    output logic        reset_ack,
    output logic [1:0]  seq_state,
    output logic [1:0]  fault_cause,
    output logic        ramp_timed_out
);

    // Index CAUSE_WDG carries the watchdog pin, CAUSE_INST the instant pin.
    logic [1:0] sync_lvl;
    logic [1:0] sync_rise;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync [1:0] (
        .clk      (clk),
        .aresetn  (aresetn),
        .async_in ({instant_reset_in, watchdog_in}),
        .level    (sync_lvl),
        .rise     (sync_rise)
    );

    logic hb_rise, inst_lvl, unused_sync;
    assign hb_rise     = sync_rise[CAUSE_WDG];
    assign inst_lvl    = sync_lvl[CAUSE_INST];
    assign unused_sync = sync_lvl[CAUSE_WDG] ^ sync_rise[CAUSE_INST];

    seq_state_t  state_q, state_nxt;
    logic [1:0]  cause_q, cause_nxt;
    logic [31:0] wdg_cnt_q;
    logic        clr_q, ack_q, dac_q;
    logic        clr_rise, wdg_active, wdg_fault, inst_fault;
    logic        any_ramp, all_settled, ramp_expired;

    assign clr_rise   = clear_fault & ~clr_q;
    assign wdg_active = (state_q == ST_MONITOR) && wdg_en && (wdg_timeout != 32'd0);
    // A heartbeat in the expiry cycle restarts the count instead of faulting.
    assign wdg_fault  = wdg_active && !hb_rise && (wdg_cnt_q == wdg_timeout - 32'd1);
    assign inst_fault = (state_q == ST_MONITOR) && inst_en && inst_lvl;

`ifdef FAULT_SEQ_RAMP_EN
    logic [31:0]       ramp_cnt_q;
    logic [1:0]        srd_q;
    logic              rto_q, rto_set;
    logic [NUM_CH-1:0] ch_settled;

    assign ch_settled[0] = !ramping_enable[0] || (ramp_state_0 == RAMP_OFF);
    assign ch_settled[1] = !ramping_enable[1] || (ramp_state_1 == RAMP_OFF);
    assign any_ramp      = |ramping_enable;
    assign all_settled   = &ch_settled;
    assign ramp_expired  = (ramp_timeout != 32'd0) && (ramp_cnt_q == ramp_timeout - 32'd1);
    // Settling in the expiry cycle counts as a clean ramp-down.
    assign rto_set       = (state_q == ST_RAMP_DOWN) && !all_settled && ramp_expired;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ramp_cnt_q <= '0;
            srd_q      <= '0;
            rto_q      <= 1'b0;
        end else begin
            // Counter is zero on RAMP_DOWN entry, frozen through HALT.
            if (state_q == ST_RAMP_DOWN)
                ramp_cnt_q <= sat_inc(ramp_cnt_q);
            else if (state_nxt == ST_MONITOR)
                ramp_cnt_q <= '0;

            // Tracks ramping_enable while ramping, then holds through HALT.
            if (state_nxt == ST_RAMP_DOWN)
                srd_q <= ramping_enable;
            else if (state_nxt == ST_MONITOR)
                srd_q <= '0;

            if (state_nxt == ST_MONITOR)
                rto_q <= 1'b0;
            else if (rto_set)
                rto_q <= 1'b1;
        end
    end

    assign start_ramp_down = srd_q;
    assign ramp_timed_out  = rto_q;
`else
    logic unused_ramp;
    assign unused_ramp     = ^{ramping_enable, ramp_state_0, ramp_state_1, ramp_timeout};
    assign any_ramp        = 1'b0;
    assign all_settled     = 1'b1;
    assign ramp_expired    = 1'b0;
    assign start_ramp_down = 2'b00;
    assign ramp_timed_out  = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        cause_nxt = cause_q;
        case (state_q)
            ST_MONITOR: begin
                if (wdg_fault || inst_fault) begin
                    cause_nxt[CAUSE_WDG]  = wdg_fault;
                    cause_nxt[CAUSE_INST] = inst_fault;
                    state_nxt = any_ramp ? ST_RAMP_DOWN : ST_HALT;
                end
            end
            ST_RAMP_DOWN: begin
                if (all_settled || ramp_expired)
                    state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (clr_rise && (!inst_lvl || !inst_en)) begin
                    state_nxt = ST_MONITOR;
                    cause_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_MONITOR;
                cause_nxt = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as seq_state.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_MONITOR;
            cause_q   <= '0;
            wdg_cnt_q <= '0;
            clr_q     <= 1'b0;
            ack_q     <= 1'b0;
            dac_q     <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cause_q <= cause_nxt;
            clr_q   <= clear_fault;
            ack_q   <= (state_nxt != ST_MONITOR);
            dac_q   <= (state_nxt != ST_HALT);
            if (!wdg_active || hb_rise || state_nxt != ST_MONITOR)
                wdg_cnt_q <= '0;
            else
                wdg_cnt_q <= sat_inc(wdg_cnt_q);
        end
    end

    assign seq_state   = state_q;
    assign fault_cause = cause_q;
    assign reset_ack   = ack_q;
    assign dac_aresetn = dac_q;

endmodule

// File: tb/tb_fault_shutdown_sequencer.sv
module tb_fault_shutdown_sequencer;

    localparam logic [1:0] S_MON  = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] ON     = 2'b10;
    localparam logic [1:0] OFF    = 2'b00;
`ifdef FAULT_SEQ_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        wdg_en = 1'b0, inst_en = 1'b0, watchdog_in = 1'b0;
    logic        instant_reset_in = 1'b0, clear_fault = 1'b0;
    logic [31:0] wdg_timeout = 32'd1000, ramp_timeout = 32'd0;
    logic [1:0]  ramping_enable = 2'b00, ramp_state_0 = ON, ramp_state_1 = ON;
    logic [1:0]  start_ramp_down, seq_state, fault_cause;
    logic        dac_aresetn, reset_ack, ramp_timed_out;

    fault_shutdown_sequencer #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .wdg_en           (wdg_en),
        .inst_en          (inst_en),
        .watchdog_in      (watchdog_in),
        .instant_reset_in (instant_reset_in),
        .clear_fault      (clear_fault),
        .wdg_timeout      (wdg_timeout),
        .ramp_timeout     (ramp_timeout),
        .ramping_enable   (ramping_enable),
        .ramp_state_0     (ramp_state_0),
        .ramp_state_1     (ramp_state_1),
        .start_ramp_down  (start_ramp_down),
        .dac_aresetn      (dac_aresetn),
        .reset_ack        (reset_ack),
        .seq_state        (seq_state),
        .fault_cause      (fault_cause),
        .ramp_timed_out   (ramp_timed_out)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       ack;
        logic       dac;
        logic [1:0] cause;
        logic [1:0] srd;
        logic       rto;
    } out_t;

    typedef struct {
        logic       inst_en;
        logic       pin;
        logic       clr;
        logic [1:0] ren;
        logic [1:0] rs0;
        logic [1:0] rs1;
        int         cyc;
        out_t       exp;
    } vec_t;

    out_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic out_t mk(input logic [1:0] st, input logic ack, input logic dac,
                                input logic [1:0] cause, input logic [1:0] srd, input logic rto);
        return out_t'({st, ack, dac, cause, srd, rto});
    endfunction

    function automatic vec_t mkv(input logic ie, input logic pin, input logic clr,
                                 input logic [1:0] ren, input logic [1:0] rs0,
                                 input logic [1:0] rs1, input int cyc, input out_t exp);
        vec_t v;
        v.inst_en = ie; v.pin = pin; v.clr = clr; v.ren = ren;
        v.rs0 = rs0; v.rs1 = rs1; v.cyc = cyc; v.exp = exp;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_check(input string name);
        out_t a, e;
        a = {seq_state, reset_ack, dac_aresetn, fault_cause, start_ramp_down, ramp_timed_out};
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = sb_q.pop_front();
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d ack=%b dac=%b cause=%b srd=%b rto=%b, want st=%0d ack=%b dac=%b cause=%b srd=%b rto=%b",
                     name, a.st, a.ack, a.dac, a.cause, a.srd, a.rto,
                     e.st, e.ack, e.dac, e.cause, e.srd, e.rto);
        end
    endtask

    task automatic expect_after(input out_t e, input int n, input string name);
        sb_q.push_back(e);
        step(n);
        sb_check(name);
    endtask

    task automatic clear_to_monitor(input string name);
        clear_fault = 1'b1;
        expect_after(mk(S_MON, 0, 1, 2'b00, 2'b00, 0), 1, name);
        clear_fault = 1'b0;
        step(2);
    endtask

    out_t MON, H_INST, H_WDG;
    vec_t tbl[14];

    initial begin
        MON    = mk(S_MON,  0, 1, 2'b00, 2'b00, 0);
        H_INST = mk(S_HALT, 1, 0, 2'b10, 2'b00, 0);
        H_WDG  = mk(S_HALT, 1, 0, 2'b01, 2'b00, 0);

        tbl[0]  = mkv(1, 0, 0, 2'b00, ON, ON,  5, MON);
        tbl[1]  = mkv(1, 1, 0, 2'b00, ON, ON,  5, H_INST);
        tbl[2]  = mkv(1, 1, 1, 2'b00, ON, ON,  4, H_INST);   // clear ignored while instant high
        tbl[3]  = mkv(1, 1, 0, 2'b00, ON, ON,  2, H_INST);
        tbl[4]  = mkv(1, 0, 0, 2'b00, ON, ON,  5, H_INST);   // no clear edge yet
        tbl[5]  = mkv(1, 0, 1, 2'b00, ON, ON,  2, MON);
        tbl[6]  = mkv(0, 1, 0, 2'b00, ON, ON,  5, MON);      // instant disabled
        tbl[7]  = mkv(0, 1, 1, 2'b00, ON, ON,  3, MON);      // clear in MONITOR
        tbl[8]  = mkv(1, 1, 0, 2'b00, ON, ON,  5, H_INST);
        tbl[9]  = mkv(0, 1, 1, 2'b00, ON, ON,  2, MON);      // inst_en=0 allows clear
        tbl[10] = mkv(0, 0, 0, 2'b10, ON, ON,  5, MON);
        tbl[11] = mkv(1, 1, 0, 2'b10, ON, ON,  5,
                      RAMP ? mk(S_RD, 1, 1, 2'b10, 2'b10, 0) : H_INST);
        tbl[12] = mkv(1, 0, 0, 2'b10, ON, OFF, 5,
                      RAMP ? mk(S_HALT, 1, 0, 2'b10, 2'b10, 0) : H_INST);
        tbl[13] = mkv(1, 0, 1, 2'b10, ON, ON,  3, MON);

        // Reset values while aresetn is low.
        step(3);
        sb_q.push_back(MON);
        sb_check("reset_state");
        aresetn = 1'b1;
        step(2);

        // Table: instant path and clear rules.
        for (int i = 0; i < 14; i++) begin
            inst_en          = tbl[i].inst_en;
            instant_reset_in = tbl[i].pin;
            clear_fault      = tbl[i].clr;
            ramping_enable   = tbl[i].ren;
            ramp_state_0     = tbl[i].rs0;
            ramp_state_1     = tbl[i].rs1;
            expect_after(tbl[i].exp, tbl[i].cyc, $sformatf("vec%0d", i));
        end
        clear_fault = 1'b0; inst_en = 1'b0; instant_reset_in = 1'b0;
        ramping_enable = 2'b00;
        step(4);

        // Heartbeat every 500 cycles for 10000 cycles, then silence.
        wdg_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            watchdog_in = 1'b1;
            step(10);
            watchdog_in = 1'b0;
            expect_after(MON, 490, "hb_running");
        end
        // Last pin edge was 500 cycles ago; clear lands 3 cycles after it.
        expect_after(MON, 502, "hb_stop_before");
        expect_after(H_WDG, 1, "hb_stop_expire");
        wdg_en = 1'b0;
        clear_to_monitor("hb_stop_clear");

        // Heartbeat arriving in the expiry cycle wins.
        wdg_en = 1'b1;
        step(997);
        watchdog_in = 1'b1;
        expect_after(MON, 3, "hb_expiry_wins");
        expect_after(MON, 500, "hb_expiry_restart");
        watchdog_in = 1'b0; wdg_en = 1'b0;
        step(3);

        // Heartbeat one cycle too late.
        wdg_en = 1'b1;
        step(998);
        watchdog_in = 1'b1;
        expect_after(MON, 1, "hb_late_before");
        expect_after(H_WDG, 1, "hb_late_expire");
        watchdog_in = 1'b0; wdg_en = 1'b0;
        step(3);
        clear_to_monitor("hb_late_clear");

        // Watchdog expiry and instant reset in the same cycle.
        wdg_en = 1'b1; inst_en = 1'b1;
        step(997);
        instant_reset_in = 1'b1;
        expect_after(mk(S_HALT, 1, 0, 2'b11, 2'b00, 0), 3, "both_fault");
        clear_fault = 1'b1;
        expect_after(mk(S_HALT, 1, 0, 2'b11, 2'b00, 0), 2, "both_clear_blocked");
        clear_fault = 1'b0; instant_reset_in = 1'b0;
        step(4);
        clear_fault = 1'b1; wdg_en = 1'b0;
        expect_after(MON, 1, "both_clear_dac");
        clear_fault = 1'b0; inst_en = 1'b0;
        step(2);

        // Ramp-down with both channels, ch0 settles at 200, ch1 at 300.
        ramping_enable = 2'b11; ramp_state_0 = ON; ramp_state_1 = ON;
        ramp_timeout = 32'd0; inst_en = 1'b1;
        instant_reset_in = 1'b1;
        if (RAMP) begin
            expect_after(mk(S_RD, 1, 1, 2'b10, 2'b11, 0), 3, "ramp_enter");
            instant_reset_in = 1'b0;
            step(199);
            ramp_state_0 = OFF;
            expect_after(mk(S_RD, 1, 1, 2'b10, 2'b11, 0), 100, "ramp_cycle300");
            ramp_state_1 = OFF;
            expect_after(mk(S_HALT, 1, 0, 2'b10, 2'b11, 0), 1, "ramp_halt301");
        end else begin
            expect_after(H_INST, 3, "ramp_off_direct_halt");
            instant_reset_in = 1'b0;
            step(3);
        end
        clear_to_monitor("ramp_clear");
        ramp_state_0 = ON; ramp_state_1 = ON;

        // Ramp timeout of 50 with a channel that never settles.
        ramping_enable = 2'b01; ramp_timeout = 32'd50;
        instant_reset_in = 1'b1;
        if (RAMP) begin
            step(3);
            instant_reset_in = 1'b0;
            expect_after(mk(S_RD, 1, 1, 2'b10, 2'b01, 0), 49, "rto_cycle50");
            expect_after(mk(S_HALT, 1, 0, 2'b10, 2'b01, 1), 1, "rto_halt");
        end else begin
            expect_after(H_INST, 3, "rto_off_direct_halt");
            instant_reset_in = 1'b0;
            step(3);
        end
        clear_to_monitor("rto_clear");

        // Asynchronous reset in the middle of the sequence.
        ramping_enable = 2'b11; ramp_timeout = 32'd0;
        instant_reset_in = 1'b1;
        step(3);
        instant_reset_in = 1'b0;
        step(5);
        aresetn = 1'b0;
        #1;
        sb_q.push_back(MON);
        sb_check("async_reset");
        step(2);
        aresetn = 1'b1;
        expect_after(MON, 4, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
